// File: rtl/led_ram_arbiter.sv
// rtl/led_ram_arbiter.sv - arbitrates pen writes and scanner reads onto a one-hot addressed LED RAM
module led_ram_arbiter #(
    parameter int SCAN_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pen_req,
    input  logic [2:0] pen_row,
    input  logic [2:0] pen_col,
    input  logic [3:0] pen_data,
    output logic       pen_ack,
    input  logic       scan_req,
    input  logic [2:0] scan_row,
    input  logic [2:0] scan_col,
    output logic       scan_ack,
    output logic [3:0] scan_data,
    output logic [7:0] ram_addr_row,
    output logic [7:0] ram_addr_col,
    output logic [3:0] ram_data,
    output logic       ram_we,
    input  logic [3:0] ram_led_data,
    output logic       busy
);

    localparam logic [3:0] LP_BURST = 4'(SCAN_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_ADDR,
        S_RD_WAIT
    } state_t;

    state_t     r_state;
    logic       r_pen_ack;
    logic       r_scan_ack;
    logic [3:0] r_scan_data;
    logic [7:0] r_ram_addr_row;
    logic [7:0] r_ram_addr_col;
    logic [3:0] r_ram_data;
    logic       r_ram_we;
    logic       r_busy;
    logic [3:0] r_scan_streak;

    logic w_pick_pen;
    logic w_grant_pen;
    logic w_grant_scan;

    function automatic logic [7:0] f_onehot(input logic [2:0] a);
        f_onehot = 8'd1 << a;
    endfunction

    // The turn decision uses raw requests; if the chosen side is still acking,
    // nobody is granted this cycle so the other side cannot jump the queue.
    assign w_pick_pen   = pen_req && (!scan_req || (r_scan_streak == LP_BURST));
    assign w_grant_pen  = (r_state == S_IDLE) && w_pick_pen && !r_pen_ack;
    assign w_grant_scan = (r_state == S_IDLE) && !w_pick_pen && scan_req && !r_scan_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pen_ack      <= 1'b0;
            r_scan_ack     <= 1'b0;
            r_scan_data    <= 4'h0;
            r_ram_addr_row <= 8'b0000_0001;
            r_ram_addr_col <= 8'b0000_0001;
            r_ram_data     <= 4'h0;
            r_ram_we       <= 1'b0;
            r_busy         <= 1'b0;
            r_scan_streak  <= 4'd0;
        end else begin
            r_pen_ack  <= 1'b0;
            r_scan_ack <= 1'b0;
            r_ram_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_pen) begin
                        r_state        <= S_WR_SETUP;
                        r_busy         <= 1'b1;
                        r_ram_addr_row <= f_onehot(pen_row);
                        r_ram_addr_col <= f_onehot(pen_col);
                        r_ram_data     <= pen_data;
                        r_scan_streak  <= 4'd0;
                    end else if (w_grant_scan) begin
                        r_state        <= S_RD_ADDR;
                        r_busy         <= 1'b1;
                        r_ram_addr_row <= f_onehot(scan_row);
                        r_ram_addr_col <= f_onehot(scan_col);
                        if (r_scan_streak != LP_BURST) begin
                            r_scan_streak <= r_scan_streak + 4'd1;
                        end
                    end
                end
                S_WR_SETUP: begin
                    r_state  <= S_WR_PULSE;
                    r_ram_we <= 1'b1;
                end
                S_WR_PULSE: begin
                    r_state   <= S_WR_HOLD;
                    r_pen_ack <= 1'b1;
                end
                S_WR_HOLD: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_scan_ack  <= 1'b1;
                    r_scan_data <= ram_led_data;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pen_ack      = r_pen_ack;
    assign scan_ack     = r_scan_ack;
    assign scan_data    = r_scan_data;
    assign ram_addr_row = r_ram_addr_row;
    assign ram_addr_col = r_ram_addr_col;
    assign ram_data     = r_ram_data;
    assign ram_we       = r_ram_we;
    assign busy         = r_busy;

endmodule

// File: doc/led_ram_arbiter.md
LED_RAM_ARBITER -- requirements
Module: led_ram_arbiter

Interface
REQ-001 Parameter SCAN_BURST, default 4, max consecutive scan grants while a pen request waits (1..15).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pen_req  in  1  pen write request, held high until pen_ack.
REQ-006 pen_row / pen_col  in  3 each  binary write cell address.
REQ-007 pen_data  in  4  write data.
REQ-008 pen_ack  out  1  one-cycle pulse, write completed.
REQ-009 scan_req  in  1  scanner read request, held high until scan_ack.
REQ-010 scan_row / scan_col  in  3 each  binary read cell address.
REQ-011 scan_ack  out  1  one-cycle pulse, scan_data valid.
REQ-012 scan_data  out  4  read data, held until next scan_ack.
REQ-013 ram_addr_row / ram_addr_col  out  8 each  one-hot RAM address.
REQ-014 ram_data  out  4  RAM write data.
REQ-015 ram_we  out  1  RAM write strobe.
REQ-016 ram_led_data  in  4  RAM registered read data (1-cycle latency from address).
REQ-017 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_WAIT; all outputs registered.
REQ-019 Grants SHALL occur only in IDLE; requester fields SHALL be captured at grant and used for the whole transaction.
REQ-020 A requester whose ack is high in the current cycle SHALL NOT be granted that cycle.
REQ-021 Pen only requesting: grant pen; scan only: grant scan.
REQ-022 Both requesting: grant scan unless scan_streak == SCAN_BURST, then grant pen.
REQ-023 scan_streak (4-bit) SHALL increment on scan grant saturating at SCAN_BURST, clear to 0 on pen grant.
REQ-024 Write: grant at t -> WR_SETUP t+1 (addr/data driven, we=0) -> WR_PULSE t+2 (we=1) -> WR_HOLD t+3 (we=0, addr/data held, pen_ack=1) -> IDLE t+4.
REQ-025 ram_we SHALL be high only in WR_PULSE, exactly one cycle per write.
REQ-026 Read: grant at t -> RD_ADDR t+1 (addr driven) -> RD_WAIT t+2 (ram_led_data captured at end of cycle) -> IDLE t+3 with scan_ack=1 and scan_data valid.
REQ-027 Binary-to-one-hot: addr n -> bit n set, all others clear.
REQ-028 ram_addr_*, ram_data SHALL hold last driven value in IDLE.
REQ-029 Requester dropping req mid-transaction SHALL NOT abort; ack still pulses.
REQ-030 Back-to-back: req held after ack -> next grant no earlier than cycle after ack.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, ram_we=0, pen_ack=0, scan_ack=0, busy=0, scan_data=0, ram_data=0, ram_addr_row=ram_addr_col=8'b0000_0001, scan_streak=0.
REQ-032 Reset mid-write SHALL drop the transaction with no ack; after release FSM accepts new requests in the first IDLE cycle.

Verification
REQ-033 Single write pen_row=3 pen_col=5 pen_data=4'hA -> ram_addr_row=8'h08, ram_addr_col=8'h20, ram_data=A from t+1; ram_we high only t+2; pen_ack at t+3.
REQ-034 Single read scan_row=7 scan_col=0, RAM model returns 4'h6 -> addr 8'h80/8'h01 at t+1; scan_ack at t+3 with scan_data=6.
REQ-035 Both held continuously, SCAN_BURST=4 -> grant order S,S,S,S,P,S,S,S,S,P; no requester starved.
REQ-036 rst_n asserted during WR_PULSE -> ram_we 0 asynchronously, no pen_ack, all outputs at reset values.
REQ-037 pen_req dropped one cycle after grant -> write completes with captured fields, single pen_ack, single ram_we pulse.
REQ-038 scan_req held high across ack -> exactly one scan_ack per transaction, re-grant no earlier than cycle after ack.
